// File: rtl/uart_rx.sv
// 8N1 UART receiver: double-flop synchroniser, mid-bit start validation and
// centre sampling of data and stop bits, with one-cycle valid / frame_err strobes.
module uart_rx #(
   parameter int CYCLES = 10416
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int HALF = CYCLES / 2;
   localparam int CW   = $clog2(CYCLES);

   localparam logic [CW-1:0] CNT_LAST  = CW'(CYCLES - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

   typedef enum logic [2:0] {
      s_idle,
      s_start,
      s_data,
      s_stop,
      s_break
   } state_t;

   state_t          state;
   state_t          state_next;
   logic            rx_m;
   logic            rx_s;
   logic [CW-1:0]   clock_count;
   logic [CW-1:0]   count_next;
   logic [2:0]      bit_index;
   logic [2:0]      index_next;
   logic [7:0]      shift_reg;
   logic [7:0]      shift_next;
   logic [7:0]      data_next;
   logic            valid_next;
   logic            ferr_next;

   // The line idles high, so the synchroniser resets to 1 to avoid a phantom start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= s_idle;
         clock_count <= '0;
         bit_index   <= '0;
         shift_reg   <= '0;
         data        <= '0;
         valid       <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         state       <= state_next;
         clock_count <= count_next;
         bit_index   <= index_next;
         shift_reg   <= shift_next;
         data        <= data_next;
         valid       <= valid_next;
         frame_err   <= ferr_next;
      end
   end

   always_comb begin
      state_next = state;
      count_next = clock_count;
      index_next = bit_index;
      shift_next = shift_reg;
      data_next  = data;
      valid_next = 1'b0;
      ferr_next  = 1'b0;

      case (state)
         s_idle: begin
            if (!rx_s) begin
               count_next = '0;
               state_next = s_start;
            end
         end

         // A start bit that is high again at its centre was a glitch; drop it silently.
         s_start: begin
            if (clock_count == HALF_LAST) begin
               count_next = '0;
               if (!rx_s) begin
                  index_next = '0;
                  state_next = s_data;
               end else begin
                  state_next = s_idle;
               end
            end else begin
               count_next = clock_count + 1'b1;
            end
         end

         s_data: begin
            if (clock_count == CNT_LAST) begin
               shift_next[bit_index] = rx_s;
               count_next            = '0;
               if (bit_index == 3'd7) begin
                  state_next = s_stop;
               end else begin
                  index_next = bit_index + 3'd1;
               end
            end else begin
               count_next = clock_count + 1'b1;
            end
         end

         s_stop: begin
            if (clock_count == CNT_LAST) begin
               count_next = '0;
               if (rx_s) begin
                  data_next  = shift_reg;
                  valid_next = 1'b1;
                  state_next = s_idle;
               end else begin
                  ferr_next  = 1'b1;
                  state_next = s_break;
               end
            end else begin
               count_next = clock_count + 1'b1;
            end
         end

         // Holding here until the line recovers keeps a break from decoding as 0x00 frames.
         s_break: begin
            if (rx_s) begin
               state_next = s_idle;
            end
         end

         default: begin
            state_next = s_idle;
         end
      endcase
   end

   assign busy = (state != s_idle);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a 16-cycle-per-bit instance for functional cases and
// a 64-cycle-per-bit instance driven with skewed baud rates.
module tb_uart_rx;

   localparam int C    = 16;
   localparam int HALF = C / 2;
   localparam int C2   = 64;

   typedef struct packed {
      logic [7:0] tx;
      logic       stopBit;
      logic       expValid;
      logic       expFerr;
      logic [7:0] expData;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx;
   logic       rx64;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       busy;
   logic [7:0] data64;
   logic       valid64;
   logic       ferr64;
   logic       busy64;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   int validPulses = 0, validHigh = 0, ferrPulses = 0, ferrHigh = 0, bothCnt = 0;
   int lastValidCyc = 0;
   logic prevValid = 1'b0, prevFerr = 1'b0;
   logic [7:0] rxq[$];

   logic trackBusy = 1'b0;
   int idleRun = 0, maxIdleRun = 0;

   int valid64Pulses = 0, ferr64Pulses = 0;
   logic prevValid64 = 1'b0, prevFerr64 = 1'b0;
   logic [7:0] q64[$];
   logic [7:0] exp64[$];

   uart_rx #(.CYCLES(C)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (rx),
      .data      (data),
      .valid     (valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   uart_rx #(.CYCLES(C2)) dut64 (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (rx64),
      .data      (data64),
      .valid     (valid64),
      .frame_err (ferr64),
      .busy      (busy64)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Strobe observers run on the falling edge, well away from the sampling edge.
   always @(negedge clk) begin
      if (valid) begin
         validHigh++;
         if (!prevValid) begin
            validPulses++;
            lastValidCyc = cyc;
            rxq.push_back(data);
         end
      end
      if (frame_err) begin
         ferrHigh++;
         if (!prevFerr) ferrPulses++;
      end
      if (valid && frame_err) bothCnt++;
      prevValid = valid;
      prevFerr  = frame_err;
      if (trackBusy) begin
         if (!busy) begin
            idleRun++;
            if (idleRun > maxIdleRun) maxIdleRun = idleRun;
         end else begin
            idleRun = 0;
         end
      end
      if (valid64 && !prevValid64) begin
         valid64Pulses++;
         q64.push_back(data64);
      end
      if (ferr64 && !prevFerr64) ferr64Pulses++;
      prevValid64 = valid64;
      prevFerr64  = ferr64;
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic driveLine(input bit line64, input logic v);
      if (line64) rx64 = v;
      else        rx   = v;
   endtask

   // Sends one 8N1 frame starting at a falling edge; the line is left at the stop level.
   task automatic applyStimulus(input logic [7:0] b, input logic stopBit, input int period,
                                input bit line64, output int kEdge);
      kEdge = cyc + 1;
      driveLine(line64, 1'b0);
      repeat (period) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         driveLine(line64, b[i]);
         repeat (period) @(negedge clk);
      end
      driveLine(line64, stopBit);
      repeat (period) @(negedge clk);
   endtask

   initial begin
      vec_t       tbl[8];
      int         k;
      int         vp0, fp0;
      logic [7:0] d0;
      logic [7:0] b;

      tbl[0] = '{8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
      tbl[1] = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'hFF};
      tbl[2] = '{8'h55, 1'b0, 1'b0, 1'b1, 8'hFF};
      tbl[3] = '{8'h81, 1'b1, 1'b1, 1'b0, 8'h81};
      tbl[4] = '{8'h01, 1'b1, 1'b1, 1'b0, 8'h01};
      tbl[5] = '{8'h80, 1'b1, 1'b1, 1'b0, 8'h80};
      tbl[6] = '{8'h3C, 1'b0, 1'b0, 1'b1, 8'h80};
      tbl[7] = '{8'hC3, 1'b1, 1'b1, 1'b0, 8'hC3};

      rx    = 1'b1;
      rx64  = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_data", data, 8'h00);
      checkOutput("reset_valid", valid, 0);
      checkOutput("reset_frame_err", frame_err, 0);
      checkOutput("reset_busy", busy, 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Single byte with exact strobe timing.
      vp0 = validPulses;
      fp0 = ferrPulses;
      applyStimulus(8'hA5, 1'b1, C, 1'b0, k);
      rx = 1'b1;
      repeat (C) @(negedge clk);
      checkOutput("single_valid_count", validPulses - vp0, 1);
      checkOutput("single_valid_edge", lastValidCyc, k + HALF + 2 + 9 * C);
      checkOutput("single_data", data, 8'hA5);
      checkOutput("single_ferr_count", ferrPulses - fp0, 0);

      for (int i = 0; i < 8; i++) begin
         vp0 = validPulses;
         fp0 = ferrPulses;
         applyStimulus(tbl[i].tx, tbl[i].stopBit, C, 1'b0, k);
         rx = 1'b1;
         repeat (2 * C) @(negedge clk);
         checkOutput($sformatf("vec%0d_valid", i), validPulses - vp0, int'(tbl[i].expValid));
         checkOutput($sformatf("vec%0d_ferr", i), ferrPulses - fp0, int'(tbl[i].expFerr));
         checkOutput($sformatf("vec%0d_data", i), data, tbl[i].expData);
         checkOutput($sformatf("vec%0d_busy", i), busy, 0);
      end

      // Back-to-back frames with no idle gap.
      rxq.delete();
      idleRun    = 0;
      maxIdleRun = 0;
      trackBusy  = 1'b1;
      applyStimulus(8'h00, 1'b1, C, 1'b0, k);
      applyStimulus(8'hFF, 1'b1, C, 1'b0, k);
      applyStimulus(8'h3C, 1'b1, C, 1'b0, k);
      trackBusy = 1'b0;
      rx = 1'b1;
      repeat (2 * C) @(negedge clk);
      checkOutput("b2b_count", rxq.size(), 3);
      if (rxq.size() == 3) begin
         checkOutput("b2b_byte0", rxq[0], 8'h00);
         checkOutput("b2b_byte1", rxq[1], 8'hFF);
         checkOutput("b2b_byte2", rxq[2], 8'h3C);
      end
      checkOutput("b2b_idle_gap_ok", int'(maxIdleRun <= HALF + 2), 1);

      // Five-cycle glitch is rejected at the mid-start check.
      vp0 = validPulses;
      fp0 = ferrPulses;
      d0  = data;
      k   = cyc + 1;
      rx  = 1'b0;
      repeat (5) @(negedge clk);
      rx = 1'b1;
      while (cyc < k + 9) @(negedge clk);
      checkOutput("glitch_busy_before_check", busy, 1);
      @(negedge clk);
      checkOutput("glitch_busy_after_check", busy, 0);
      repeat (2 * C) @(negedge clk);
      checkOutput("glitch_valid", validPulses - vp0, 0);
      checkOutput("glitch_ferr", ferrPulses - fp0, 0);
      checkOutput("glitch_data", data, d0);

      // Framing error, then a 40-bit break, then recovery.
      vp0 = validPulses;
      fp0 = ferrPulses;
      d0  = data;
      applyStimulus(8'h55, 1'b0, C, 1'b0, k);
      repeat (40 * C) @(negedge clk);
      checkOutput("break_ferr_count", ferrPulses - fp0, 1);
      checkOutput("break_valid_count", validPulses - vp0, 0);
      checkOutput("break_data_kept", data, d0);
      checkOutput("break_busy", busy, 1);
      rx = 1'b1;
      repeat (2 * C) @(negedge clk);
      vp0 = validPulses;
      applyStimulus(8'h81, 1'b1, C, 1'b0, k);
      rx = 1'b1;
      repeat (2 * C) @(negedge clk);
      checkOutput("recover_valid", validPulses - vp0, 1);
      checkOutput("recover_data", data, 8'h81);

      // Reset asserted in the middle of data bit 3.
      vp0 = validPulses;
      fp0 = ferrPulses;
      b   = 8'h7E;
      rx  = 1'b0;
      repeat (C) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         rx = b[i];
         repeat (C) @(negedge clk);
      end
      rx = b[3];
      repeat (C / 2) @(negedge clk);
      checkOutput("midreset_busy_before", busy, 1);
      rst_n = 1'b0;
      #2;
      checkOutput("midreset_data", data, 8'h00);
      checkOutput("midreset_valid", valid, 0);
      checkOutput("midreset_ferr", frame_err, 0);
      checkOutput("midreset_busy", busy, 0);
      rx = 1'b1;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (2 * C) @(negedge clk);
      checkOutput("midreset_no_strobe", validPulses + ferrPulses - vp0 - fp0, 0);
      applyStimulus(8'h7E, 1'b1, C, 1'b0, k);
      rx = 1'b1;
      repeat (2 * C) @(negedge clk);
      checkOutput("postreset_valid", validPulses - vp0, 1);
      checkOutput("postreset_data", data, 8'h7E);

      // Baud skew on the 64-cycle instance: slow then fast sender.
      q64.delete();
      exp64.delete();
      fp0 = ferr64Pulses;
      for (int i = 0; i < 60; i++) begin
         b = 8'($urandom_range(0, 255));
         exp64.push_back(b);
         applyStimulus(b, 1'b1, (i < 30) ? C2 + 1 : C2 - 1, 1'b1, k);
      end
      rx64 = 1'b1;
      repeat (2 * C2) @(negedge clk);
      checkOutput("skew_count", q64.size(), 60);
      checkOutput("skew_ferr", ferr64Pulses - fp0, 0);
      for (int i = 0; i < 60; i++) begin
         if (i < q64.size()) checkOutput($sformatf("skew_byte%0d", i), q64[i], exp64[i]);
      end

      checkOutput("valid_one_cycle", validHigh, validPulses);
      checkOutput("ferr_one_cycle", ferrHigh, ferrPulses);
      checkOutput("valid_ferr_exclusive", bothCnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
